mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one downstream memory port between the fetch requester (I) and the data requester (D).
//  Sits between core ireq/iresp, dreq/dresp and the single memory/cache port.
//  D has priority, since a pending load/store stalls the whole pipeline.
//  A starvation counter forces an I grant after STARVE_LIMIT consecutive D wins.
//  The owner is locked from grant until its data_ok, and responses are steered to the owner only.
// PARAMETERS
//  ADDR_W        64  address width
//  DATA_W        64  data width
//  STARVE_LIMIT   4  consecutive D grants with I pending before I is forced (>=1)
//  CNT_W          3  starvation counter width; must hold STARVE_LIMIT
// PORTS
//  clk           in   1        clock
//  reset         in   1        synchronous, active-high reset
//  i_valid       in   1        fetch request valid; held with stable addr until i_data_ok
//  i_addr        in   ADDR_W   fetch address
//  i_addr_ok     out  1        fetch request accepted downstream
//  i_data_ok     out  1        fetch data returned; completes the I transaction
//  i_data        out  32       fetch instruction word
//  d_valid       in   1        data request valid; held stable until d_data_ok
//  d_addr        in   ADDR_W   data address
//  d_size        in   3        msize_t encoding
//  d_strobe      in   DATA_W/8 byte write enables; 0 = read
//  d_wdata       in   DATA_W   store data
//  d_addr_ok     out  1        data request accepted downstream
//  d_data_ok     out  1        data returned or write done; completes the D transaction
//  d_rdata       out  DATA_W   load data
//  m_valid       out  1        downstream request valid
//  m_addr        out  ADDR_W   downstream address
//  m_size        out  3        I forces MSIZE4; D passes d_size
//  m_strobe      out  DATA_W/8 I forces 0; D passes d_strobe
//  m_wdata       out  DATA_W   I forces 0; D passes d_wdata
//  m_addr_ok     in   1        downstream accepted the request
//  m_data_ok     in   1        downstream response valid
//  m_rdata       in   DATA_W   downstream response data
//  busy          out  1        a transaction is in flight (state != IDLE)
// BEHAVIOUR
//  Reset: the following are 0 on the reset cycle and the cycle after.
//   - FSM goes to IDLE and starve_cnt is cleared.
//   - All m_* outputs, i_/d_ addr_ok and data_ok, i_data, d_rdata and busy are 0.
//  FSM states:
//   - IDLE: no owner.
//   - OWN_I: fetch owns the port.
//   - OWN_D: data owns the port.
//  Arbitration in IDLE (combinational winner, zero-cycle issue):
//   - Forced I wins when i_valid and starve_cnt == STARVE_LIMIT.
//   - Otherwise D wins when d_valid.
//   - Otherwise I wins when i_valid.
//   - The winner's request drives m_* in that same cycle.
//  Lock:
//   - When m_data_ok is 0 at the edge, the FSM goes to OWN_<winner>.
//   - When m_data_ok is 1 in the issue cycle, the transaction completes and the FSM stays IDLE.
//  OWN_x:
//   - m_* always mirrors the owner's live inputs, and m_valid = x_valid.
//   - On m_data_ok the FSM goes to IDLE at the next edge.
//   - A new grant is possible in the IDLE cycle that follows, so there is 1 bubble between owners.
//  Response steering:
//   - x_addr_ok = m_addr_ok and x_data_ok = m_data_ok only for the current owner (IDLE: the winner).
//   - The non-owner sees addr_ok = data_ok = 0.
//   - i_data = m_rdata[31:0] when ireq addr[2] == 0, else m_rdata[63:32].
//   - d_rdata = m_rdata unmodified; D-side extension is not done here.
//  Starvation counter:
//   - +1, saturating at STARVE_LIMIT, on each D grant issued while i_valid is 1.
//   - Cleared on any I grant.
//   - Unchanged otherwise.
//  Owner drops valid before data_ok (protocol violation): m_valid follows to 0 and ownership is held anyway.
//  Both idle: all m_* are 0.
//  Reset asserted mid-transaction:
//   - The FSM is forced to IDLE.
//   - Any later m_data_ok is not routed until a new grant.
// TESTING
//  1. Only I: i_valid=1, i_addr=0x8000_0004, m_data_ok at cycle 3 with m_rdata=0x1234_5678_0000_0013 -> i_data_ok=1 and i_data=0x1234_5678 at cycle 3; FSM IDLE at cycle 4.
//  2. Simultaneous: i_valid=d_valid=1 at cycle 0 -> m_addr=d_addr and strobe passed at cycle 0; i_data_ok stays 0 until D completes; I issued in the first IDLE cycle after.
//  3. Starvation with STARVE_LIMIT=4: d_valid re-asserted every IDLE cycle and i_valid held -> D wins 4 times, the 5th grant goes to I, starve_cnt is 0 afterwards.
//  4. Zero-latency response: m_addr_ok=m_data_ok=1 in the issue cycle -> data_ok pulses that cycle, the FSM never leaves IDLE, and the next request issues next cycle.
//  5. Store: d_strobe=0x0F, d_wdata=0xDEAD_BEEF, d_size=MSIZE4 -> m_strobe=0x0F, m_wdata=0xDEAD_BEEF, m_size=MSIZE4; i_data_ok stays 0 throughout.
//  6. Reset in OWN_D at cycle 2, then m_data_ok=1 at cycle 3 -> d_data_ok=0 and i_data_ok=0, busy=0, all m_*=0 at cycles 2 and 3.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Brief    : Shares one memory port between fetch (I) and data (D) requesters.
//            D wins by default, with a starvation guard that forces an I grant.
// Revision : 1.0
// ============================================================================
module mem_bus_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_valid,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_addr_ok,
  output logic                  i_data_ok,
  output logic [31:0]           i_data,
  input  logic                  d_valid,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [2:0]            d_size,
  input  logic [DATA_W/8-1:0]   d_strobe,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_addr_ok,
  output logic                  d_data_ok,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  m_valid,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [2:0]            m_size,
  output logic [DATA_W/8-1:0]   m_strobe,
  output logic [DATA_W-1:0]     m_wdata,
  input  logic                  m_addr_ok,
  input  logic                  m_data_ok,
  input  logic [DATA_W-1:0]     m_rdata,
  output logic                  busy
);

  localparam logic [2:0]       C_MSIZE4 = 3'b010;
  localparam logic [CNT_W-1:0] C_LIMIT  = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN_I = 2'd1,
    S_OWN_D = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_starve_cnt;
  logic [CNT_W-1:0] w_starve_nxt;
  logic             r_rst_hold;
  logic             w_blk;
  logic             w_sel_i;
  logic             w_sel_d;

  // Outputs stay quiet both in the reset cycle and the one right after it.
  assign w_blk = reset | r_rst_hold;

  always_ff @(posedge clk) begin
    r_rst_hold <= reset;
    if (reset) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  always_comb begin
    w_sel_i      = 1'b0;
    w_sel_d      = 1'b0;
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve_cnt;
    if (!w_blk) begin
      case (r_state)
        S_IDLE: begin
          if (i_valid && (r_starve_cnt == C_LIMIT)) w_sel_i = 1'b1;
          else if (d_valid)                         w_sel_d = 1'b1;
          else if (i_valid)                         w_sel_i = 1'b1;

          if (w_sel_i) begin
            w_starve_nxt = '0;
            if (!m_data_ok) w_state_nxt = S_OWN_I;
          end else if (w_sel_d) begin
            if (i_valid && (r_starve_cnt != C_LIMIT))
              w_starve_nxt = r_starve_cnt + CNT_W'(1);
            if (!m_data_ok) w_state_nxt = S_OWN_D;
          end
        end
        S_OWN_I: begin
          w_sel_i = 1'b1;
          if (m_data_ok) w_state_nxt = S_IDLE;
        end
        S_OWN_D: begin
          w_sel_d = 1'b1;
          if (m_data_ok) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // The selected side's live request drives the port; no selection means all zero.
  always_comb begin
    m_valid  = 1'b0;
    m_addr   = '0;
    m_size   = 3'b000;
    m_strobe = '0;
    m_wdata  = '0;
    if (w_sel_i) begin
      m_valid = i_valid;
      m_addr  = i_addr;
      m_size  = C_MSIZE4;
    end else if (w_sel_d) begin
      m_valid  = d_valid;
      m_addr   = d_addr;
      m_size   = d_size;
      m_strobe = d_strobe;
      m_wdata  = d_wdata;
    end
  end

  assign i_addr_ok = w_sel_i & m_addr_ok;
  assign i_data_ok = w_sel_i & m_data_ok;
  assign d_addr_ok = w_sel_d & m_addr_ok;
  assign d_data_ok = w_sel_d & m_data_ok;

  assign i_data  = w_blk ? 32'd0 : (i_addr[2] ? m_rdata[63:32] : m_rdata[31:0]);
  assign d_rdata = w_blk ? '0 : m_rdata;
  assign busy    = !w_blk && (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Brief    : Directed self-checking bench for mem_bus_arbiter.
// Revision : 1.0
// ============================================================================
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        i_valid;
  logic [63:0] i_addr;
  logic        i_addr_ok;
  logic        i_data_ok;
  logic [31:0] i_data;
  logic        d_valid;
  logic [63:0] d_addr;
  logic [2:0]  d_size;
  logic [7:0]  d_strobe;
  logic [63:0] d_wdata;
  logic        d_addr_ok;
  logic        d_data_ok;
  logic [63:0] d_rdata;
  logic        m_valid;
  logic [63:0] m_addr;
  logic [2:0]  m_size;
  logic [7:0]  m_strobe;
  logic [63:0] m_wdata;
  logic        m_addr_ok;
  logic        m_data_ok;
  logic [63:0] m_rdata;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  mem_bus_arbiter #(
    .ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(4), .CNT_W(3)
  ) u_dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
    .i_data_ok(i_data_ok), .i_data(i_data),
    .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe),
    .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
    .d_rdata(d_rdata),
    .m_valid(m_valid), .m_addr(m_addr), .m_size(m_size), .m_strobe(m_strobe),
    .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
    .m_rdata(m_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    i_valid   = 1'b0;  i_addr   = '0;
    d_valid   = 1'b0;  d_addr   = '0;  d_size = 3'd0;
    d_strobe  = 8'h00; d_wdata  = '0;
    m_addr_ok = 1'b0;  m_data_ok = 1'b0; m_rdata = '0;
  endtask

  // Inputs change 1 unit after the rising edge; outputs are sampled 1 unit later.
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();

    // Reset cycle with every requester and response active
    adv();
    i_valid = 1'b1; d_valid = 1'b1; d_addr = 64'h40;
    m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = '1;
    settle();
    chk("rst_m_valid",   m_valid,   0);
    chk("rst_m_addr",    m_addr,    0);
    chk("rst_busy",      busy,      0);
    chk("rst_d_addr_ok", d_addr_ok, 0);
    chk("rst_i_data_ok", i_data_ok, 0);
    chk("rst_d_rdata",   d_rdata,   0);
    chk("rst_i_data",    i_data,    0);

    // Cycle after reset: still quiet
    adv();
    reset = 1'b0;
    settle();
    chk("rst1_m_valid",   m_valid,   0);
    chk("rst1_d_data_ok", d_data_ok, 0);
    chk("rst1_d_rdata",   d_rdata,   0);

    adv();
    idle_inputs();
    settle();
    chk("idle_m_valid", m_valid, 0);
    chk("idle_busy",    busy,    0);

    // Only I, response after three cycles
    adv();
    i_valid = 1'b1; i_addr = 64'h8000_0004; m_addr_ok = 1'b1;
    settle();
    chk("t1_m_valid",   m_valid,   1);
    chk("t1_m_addr",    m_addr,    64'h8000_0004);
    chk("t1_m_size",    m_size,    3'b010);
    chk("t1_i_addr_ok", i_addr_ok, 1);
    chk("t1_d_addr_ok", d_addr_ok, 0);
    adv();
    m_addr_ok = 1'b0;
    settle();
    chk("t1_busy_c1", busy, 1);
    adv();
    adv();
    m_data_ok = 1'b1; m_rdata = 64'h1234_5678_0000_0013;
    settle();
    chk("t1_i_data_ok", i_data_ok, 1);
    chk("t1_i_data",    i_data,    32'h1234_5678);
    chk("t1_d_data_ok", d_data_ok, 0);
    adv();
    idle_inputs();
    settle();
    chk("t1_busy_c4",  busy,    0);
    chk("t1_m_valid4", m_valid, 0);
    chk("t1_m_addr4",  m_addr,  0);

    // Simultaneous requests: D first, I in the following idle cycle
    adv();
    i_valid = 1'b1; i_addr = 64'h8000_0000;
    d_valid = 1'b1; d_addr = 64'h1000; d_strobe = 8'hFF;
    d_wdata = 64'h1122_3344_5566_7788; d_size = 3'd3; m_addr_ok = 1'b1;
    settle();
    chk("t2_m_addr",    m_addr,    64'h1000);
    chk("t2_m_strobe",  m_strobe,  8'hFF);
    chk("t2_d_addr_ok", d_addr_ok, 1);
    chk("t2_i_addr_ok", i_addr_ok, 0);
    adv();
    m_addr_ok = 1'b0;
    settle();
    chk("t2_busy",    busy,    1);
    chk("t2_m_wdata", m_wdata, 64'h1122_3344_5566_7788);
    adv();
    m_data_ok = 1'b1; m_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    settle();
    chk("t2_d_data_ok", d_data_ok, 1);
    chk("t2_i_data_ok", i_data_ok, 0);
    chk("t2_d_rdata",   d_rdata,   64'hAAAA_BBBB_CCCC_DDDD);
    adv();
    d_valid = 1'b0; m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 64'h97;
    settle();
    chk("t2_i_m_addr",   m_addr,    64'h8000_0000);
    chk("t2_i_m_size",   m_size,    3'b010);
    chk("t2_i_m_strobe", m_strobe,  0);
    chk("t2_i_m_wdata",  m_wdata,   0);
    chk("t2_i_data_ok",  i_data_ok, 1);
    chk("t2_i_data",     i_data,    32'h97);
    chk("t2_i_busy",     busy,      0);
    adv();
    idle_inputs();
    settle();
    chk("t2_end_busy", busy, 0);

    // Starvation with zero-latency responses: D D D D I D D D D I
    adv();
    i_valid = 1'b1; i_addr = 64'h8000_0100;
    d_valid = 1'b1; d_addr = 64'h5000;
    m_addr_ok = 1'b1; m_data_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      logic exp_i;
      exp_i = (k == 4) || (k == 9);
      settle();
      chk($sformatf("t3_i_data_ok_%0d", k), i_data_ok, exp_i);
      chk($sformatf("t3_d_data_ok_%0d", k), d_data_ok, !exp_i);
      chk($sformatf("t3_m_addr_%0d", k),    m_addr,    exp_i ? 64'h8000_0100 : 64'h5000);
      chk($sformatf("t3_busy_%0d", k),      busy,      0);
      adv();
    end
    idle_inputs();
    settle();
    chk("t3_end_busy", busy, 0);

    // Store with I waiting; D owner briefly drops valid
    adv();
    i_valid = 1'b1; i_addr = 64'h8000_0200;
    d_valid = 1'b1; d_addr = 64'h2000; d_strobe = 8'h0F;
    d_wdata = 64'hDEAD_BEEF; d_size = 3'b010; m_addr_ok = 1'b1;
    settle();
    chk("t5_m_strobe",  m_strobe,  8'h0F);
    chk("t5_m_wdata",   m_wdata,   64'hDEAD_BEEF);
    chk("t5_m_size",    m_size,    3'b010);
    chk("t5_i_addr_ok", i_addr_ok, 0);
    adv();
    m_addr_ok = 1'b0; d_valid = 1'b0;
    settle();
    chk("t5_drop_m_valid", m_valid,  0);
    chk("t5_drop_busy",    busy,     1);
    chk("t5_drop_strobe",  m_strobe, 8'h0F);
    adv();
    d_valid = 1'b1; m_data_ok = 1'b1;
    settle();
    chk("t5_d_data_ok", d_data_ok, 1);
    chk("t5_i_data_ok", i_data_ok, 0);
    adv();
    idle_inputs();
    settle();
    chk("t5_end_busy", busy, 0);

    // Reset while D owns the port, then a stray response
    adv();
    d_valid = 1'b1; d_addr = 64'h3000; m_addr_ok = 1'b1;
    settle();
    chk("t6_d_addr_ok", d_addr_ok, 1);
    adv();
    m_addr_ok = 1'b0;
    settle();
    chk("t6_busy_c1", busy, 1);
    adv();
    reset = 1'b1; m_addr_ok = 1'b1;
    settle();
    chk("t6_c2_m_valid",   m_valid,   0);
    chk("t6_c2_busy",      busy,      0);
    chk("t6_c2_d_addr_ok", d_addr_ok, 0);
    chk("t6_c2_m_addr",    m_addr,    0);
    adv();
    reset = 1'b0; m_data_ok = 1'b1;
    settle();
    chk("t6_c3_d_data_ok", d_data_ok, 0);
    chk("t6_c3_i_data_ok", i_data_ok, 0);
    chk("t6_c3_busy",      busy,      0);
    chk("t6_c3_m_valid",   m_valid,   0);
    chk("t6_c3_m_addr",    m_addr,    0);
    adv();
    m_data_ok = 1'b0;
    settle();
    chk("t6_c4_m_valid",   m_valid,   1);
    chk("t6_c4_m_addr",    m_addr,    64'h3000);
    chk("t6_c4_d_addr_ok", d_addr_ok, 1);
    adv();
    settle();
    chk("t6_c5_busy", busy, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
